// File: rtl/instr_encode_loader_pkg.sv
// ISA constants shared by the program loader: opcodes, control bundles,
// instruction field layout, error codes, FSM states and the word packer.
package isa_pkg;

  localparam int IW = 16;

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;

  // {RegDst,Branch,RegWrite,Jump,ALUOp[1:0],MemRead,MemWrite,MemtoReg,ALUSrc}
  localparam logic [9:0] CTRL_LW   = 10'h08B;
  localparam logic [9:0] CTRL_SW   = 10'h005;
  localparam logic [9:0] CTRL_ADD  = 10'h280;
  localparam logic [9:0] CTRL_ADDI = 10'h081;
  localparam logic [9:0] CTRL_SUB  = 10'h2A0;
  localparam logic [9:0] CTRL_JMP  = 10'h070;

  localparam int OP_LSB = 13;
  localparam int RS_LSB = 10;
  localparam int RT_LSB = 7;
  localparam int RD_LSB = 4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_FULL    = 2'b10;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  function automatic logic [IW-1:0] pack_word(
    input logic [2:0]  op,
    input fmt_t        fmt,
    input logic [2:0]  rs,
    input logic [2:0]  rt,
    input logic [2:0]  rd,
    input logic [6:0]  imm,
    input logic [12:0] target
  );
    logic [IW-1:0] w;
    case (fmt)
      FMT_R:   w = {op, rs, rt, rd, 4'b0000};
      FMT_J:   w = {op, target};
      default: w = {op, rs, rt, imm};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encode_loader_ctrl_encode.sv
// Maps a 10-bit control bundle back to its opcode and instruction format;
// only exact matches of the six known bundles are legal.
module ctrl_encode
  import isa_pkg::*;
(
  input  logic [9:0] ctrl,
  output logic [2:0] opcode,
  output logic       legal,
  output fmt_t       fmt
);

  always_comb begin
    opcode = OP_LW;
    legal  = 1'b1;
    fmt    = FMT_I;
    case (ctrl)
      CTRL_LW:   begin opcode = OP_LW;   fmt = FMT_I; end
      CTRL_SW:   begin opcode = OP_SW;   fmt = FMT_I; end
      CTRL_ADD:  begin opcode = OP_ADD;  fmt = FMT_R; end
      CTRL_ADDI: begin opcode = OP_ADDI; fmt = FMT_I; end
      CTRL_SUB:  begin opcode = OP_SUB;  fmt = FMT_R; end
      CTRL_JMP:  begin opcode = OP_JMP;  fmt = FMT_J; end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: encodes control bundles into instruction words and writes
// them to sequential imem addresses starting at a per-session base address.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [9:0]    in_ctrl,
  input  logic [2:0]    in_rs,
  input  logic [2:0]    in_rt,
  input  logic [2:0]    in_rd,
  input  logic [6:0]    in_imm,
  input  logic [12:0]   in_target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state, state_next;
  logic [AW-1:0] wr_addr;
  logic          full;
  logic [2:0]    opcode;
  logic          legal;
  fmt_t          fmt;
  logic          accept;
  logic          start_ok;
  logic          hit_end;

  ctrl_encode u_ctrl_encode (
    .ctrl   (in_ctrl),
    .opcode (opcode),
    .legal  (legal),
    .fmt    (fmt)
  );

  assign accept   = in_valid && in_ready;
  assign start_ok = (state == S_IDLE) && start;
  assign hit_end  = accept && legal && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (accept && (in_last || hit_end)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD) && !full;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Write strobe, address and data are registered together so each word
  // appears on the imem port exactly one cycle after its beat is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      wr_addr    <= '0;
      full       <= 1'b0;
      count      <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        wr_addr  <= base_addr;
        count    <= '0;
        full     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_addr;
          imem_wdata <= pack_word(opcode, fmt, in_rs, in_rt, in_rd, in_imm, in_target);
          wr_addr    <= wr_addr + 1'b1;
          count      <= count + 1'b1;
          if (wr_addr == LAST_ADDR) begin
            full <= 1'b1;
            if (!in_last) begin
              err <= 1'b1;
              if (err_code == ERR_NONE) err_code <= ERR_FULL;
            end
          end
        end else begin
          err <= 1'b1;
          if (err_code == ERR_NONE) err_code <= ERR_ILLEGAL;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: sessions, encoding, illegal
// bundles, memory-full termination, reset abort and back-to-back streaming.
module tb_instr_encode_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [9:0]    in_ctrl;
  logic [2:0]    in_rs, in_rt, in_rd;
  logic [6:0]    in_imm;
  logic [12:0]   in_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_ctrl    (in_ctrl),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [9:0] c, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [6:0] imm, input logic [12:0] tgt,
                      input logic last);
    in_valid  = 1'b1;
    in_ctrl   = c;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  logic [9:0]  bundles [6] = '{10'h08B, 10'h005, 10'h280, 10'h081, 10'h2A0, 10'h070};
  logic [15:0] words   [6] = '{16'h0505, 16'h2505, 16'h4530, 16'h6505, 16'h8530, 16'hB234};

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_ctrl = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    step(); step();
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'({err, err_code}), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    reset = 1'b0;

    // 1: single R-type word, clean end
    start = 1'b1; base_addr = 8'h10;
    step();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_ready", 32'(in_ready), 32'h1);
    beat(10'h280, 3'd1, 3'd2, 3'd3, 7'h00, 13'h0000, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_we", 32'(imem_we), 32'h1);
    chk("t1_addr", 32'(imem_addr), 32'h10);
    chk("t1_wdata", 32'(imem_wdata), 32'h4530);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_count", 32'(count), 32'h1);
    step();
    chk("t1_idle", 32'({imem_we, busy, done}), 32'h0);

    // 2: J-type then I-type
    start = 1'b1; base_addr = 8'h20;
    step();
    start = 1'b0;
    chk("t2_count_clr", 32'(count), 32'h0);
    beat(10'h070, 3'd0, 3'd0, 3'd0, 7'h00, 13'h0ABC, 1'b0);
    step();
    chk("t2_w0_addr", 32'(imem_addr), 32'h20);
    chk("t2_w0_data", 32'(imem_wdata), 32'hAABC);
    beat(10'h08B, 3'd2, 3'd5, 3'd0, 7'h7F, 13'h0000, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_w1_addr", 32'(imem_addr), 32'h21);
    chk("t2_w1_data", 32'(imem_wdata), 32'h0AFF);
    chk("t2_count", 32'(count), 32'h2);
    chk("t2_done", 32'(done), 32'h1);
    step();

    // 3: illegal bundle mid-stream
    start = 1'b1; base_addr = 8'h30;
    step();
    start = 1'b0;
    beat(10'h3FF, 3'd1, 3'd1, 3'd1, 7'h01, 13'h0001, 1'b0);
    step();
    chk("t3_ill_we", 32'(imem_we), 32'h0);
    chk("t3_ill_err", 32'({err, err_code}), 32'h5);
    chk("t3_ill_count", 32'(count), 32'h0);
    beat(10'h280, 3'd4, 3'd5, 3'd6, 7'h00, 13'h0000, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t3_we", 32'(imem_we), 32'h1);
    chk("t3_addr", 32'(imem_addr), 32'h30);
    chk("t3_wdata", 32'(imem_wdata), 32'h52E0);
    chk("t3_err_sticky", 32'({err, err_code}), 32'h5);
    chk("t3_done", 32'(done), 32'h1);
    step();

    // 4: memory fills before in_last
    start = 1'b1; base_addr = 8'hFE;
    step();
    start = 1'b0;
    chk("t4_err_clr", 32'({err, err_code}), 32'h0);
    beat(10'h005, 3'd1, 3'd1, 3'd0, 7'h01, 13'h0000, 1'b0);
    step();
    chk("t4_w0_addr", 32'(imem_addr), 32'hFE);
    chk("t4_w0_data", 32'(imem_wdata), 32'h2481);
    chk("t4_ready0", 32'(in_ready), 32'h1);
    step();
    chk("t4_w1_we", 32'(imem_we), 32'h1);
    chk("t4_w1_addr", 32'(imem_addr), 32'hFF);
    chk("t4_ready1", 32'(in_ready), 32'h0);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_err", 32'({err, err_code}), 32'h6);
    chk("t4_count", 32'(count), 32'h2);
    step();
    chk("t4_no_third", 32'({imem_we, busy, done}), 32'h0);
    in_valid = 1'b0;

    // 5a: reset right after an accept drops the session
    start = 1'b1; base_addr = 8'h40;
    step();
    start = 1'b0;
    beat(10'h280, 3'd1, 3'd2, 3'd3, 7'h00, 13'h0000, 1'b0);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_we", 32'(imem_we), 32'h0);
    chk("t5_flags", 32'({busy, done, in_ready, err, err_code}), 32'h0);
    chk("t5_addr_data", 32'({imem_addr, imem_wdata}), 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    reset = 1'b0;

    // 5b: start while busy is ignored
    start = 1'b1; base_addr = 8'h50;
    step();
    start = 1'b0;
    beat(10'h280, 3'd1, 3'd2, 3'd3, 7'h00, 13'h0000, 1'b0);
    step();
    chk("t5_first_addr", 32'(imem_addr), 32'h50);
    start = 1'b1; base_addr = 8'h60;
    step();
    start = 1'b0;
    chk("t5_busy_start_addr", 32'(imem_addr), 32'h51);
    chk("t5_busy_start_count", 32'(count), 32'h2);
    in_last = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_last_addr", 32'(imem_addr), 32'h52);
    chk("t5_done", 32'(done), 32'h1);
    step();

    // 6: all six bundles streamed back-to-back
    start = 1'b1; base_addr = 8'h80;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat(bundles[i], 3'd1, 3'd2, 3'd3, 7'h05, 13'h1234, (i == 5));
      step();
      chk($sformatf("t6_we_%0d", i), 32'(imem_we), 32'h1);
      chk($sformatf("t6_addr_%0d", i), 32'(imem_addr), 32'h80 + 32'(i));
      chk($sformatf("t6_wdata_%0d", i), 32'(imem_wdata), 32'(words[i]));
    end
    in_valid = 1'b0;
    chk("t6_count", 32'(count), 32'h6);
    chk("t6_done", 32'(done), 32'h1);
    step();
    chk("t6_idle", 32'({busy, done}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
